// File: rtl/adpll_tx_pkg.sv
// Shared types and constants for the ADPLL TX serializer.
// Whitening constants are only consumed when ADPLL_TX_WHITEN_EN is defined.
package adpll_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        SHIFT     = 2'd2
    } tx_state_e;

    // Bit positions inside the sticky err vector
    localparam int ERR_UNDERRUN  = 0;
    localparam int ERR_LOCK_LOST = 1;

    // Whitening LFSR: x^7 + x^4 + 1, seeded {SEED_MSB, channel}
    localparam int   WHITEN_W   = 7;
    localparam int   WHITEN_TAP = 4;
    localparam logic SEED_MSB   = 1'b1;

    // One LFSR advance: rotate left, with the x^4 term folding the MSB back in
    function automatic logic [WHITEN_W-1:0] whiten_step(input logic [WHITEN_W-1:0] l);
        logic [WHITEN_W-1:0] n;
        n             = {l[WHITEN_W-2:0], l[WHITEN_W-1]};
        n[WHITEN_TAP] = l[WHITEN_TAP-1] ^ l[WHITEN_W-1];
        return n;
    endfunction

endpackage

// File: rtl/adpll_tx_whitener.sv
// Data whitening LFSR. Loaded with the channel seed at packet start and
// advanced once per emitted symbol; wbit is the current whitening bit.
module adpll_tx_whitener
    import adpll_tx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WHITEN_W-2:0] seed_lo,
    input  logic                advance,
    output logic                wbit
);

    logic [WHITEN_W-1:0] lfsr_q;

    // Seed load takes priority; advance only while a packet is being sent
    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= '0;
        else if (load)
            lfsr_q <= {SEED_MSB, seed_lo};
        else if (advance)
            lfsr_q <= whiten_step(lfsr_q);
    end

    assign wbit = lfsr_q[WHITEN_W-1];

endmodule

// File: rtl/adpll_tx_serializer.sv
// TX bit source for adpll_ctr. Accepts host words over valid/ready, waits for
// channel lock, then sends each word LSB-first on data_mod, one symbol every
// SYM_CLKS clocks. A one-word holding register lets the host stay ahead of
// the shifter so consecutive words go out back to back.
// Optional build macro: ADPLL_TX_WHITEN_EN (channel-seeded data whitening).
module adpll_tx_serializer
    import adpll_tx_pkg::*;
#(
    parameter int SYM_CLKS = 32,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              channel_lock,
    input  logic [5:0]        channel,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              data_mod,
    output logic              sym_strobe,
    output logic              busy,
    output logic [1:0]        err
);

    localparam int CNT_W = $clog2(SYM_CLKS);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CLKS - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;

    logic [DATA_W-1:0] hold_data_q;
    logic              hold_last_q;
    logic              hold_full_q;

    // Shift word is kept static; sh_idx_q selects the bit on the line
    logic [DATA_W-1:0] sh_data_q;
    logic [IDX_W-1:0]  sh_idx_q;
    logic              sh_last_q;

    logic [CNT_W-1:0]  sym_cnt_q;

    logic              clr;
    logic              sym_edge, bit_end, lock_abort, underrun, pkt_done;
    logic              shift_bit, hold_to_shift, abort, accept, pkt_start;
    logic              emit, emit_bit, wbit;
    logic [IDX_W-1:0]  next_idx;

    // en low behaves exactly like reset
    assign clr  = rst | ~en;
    assign busy = (state_q != IDLE);

    // Next-state logic and per-cycle control decode
    always_comb begin
        state_d       = state_q;
        next_idx      = sh_idx_q + IDX_W'(1);
        bit_end       = (sh_idx_q == BIT_LAST);
        lock_abort    = (state_q == SHIFT) && !channel_lock;
        sym_edge      = (state_q == SHIFT) && channel_lock && (sym_cnt_q == SYM_LAST);
        shift_bit     = sym_edge && !bit_end;
        pkt_done      = sym_edge && bit_end && sh_last_q;
        underrun      = sym_edge && bit_end && !sh_last_q && !hold_full_q;
        hold_to_shift = ((state_q == WAIT_LOCK) && channel_lock && hold_full_q) ||
                        (sym_edge && bit_end && !sh_last_q && hold_full_q);
        abort         = lock_abort || underrun;
        // Hold can refill in the same cycle it drains; never accept into an abort
        tx_ready      = (!hold_full_q || hold_to_shift) && en && !rst && !abort;
        accept        = tx_valid && tx_ready;
        // A word left in hold when the previous packet ended also starts a packet
        pkt_start     = (state_q == IDLE) && (accept || hold_full_q);
        emit          = hold_to_shift || shift_bit;
        emit_bit      = hold_to_shift ? hold_data_q[0] : sh_data_q[next_idx];

        case (state_q)
            IDLE:      if (pkt_start)         state_d = WAIT_LOCK;
            WAIT_LOCK: if (hold_to_shift)     state_d = SHIFT;
            SHIFT:     if (abort || pkt_done) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Holding register: load on accept, drain into shifter, drop on abort
    always_ff @(posedge clk) begin
        if (clr || abort) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
        end else if (accept) begin
            hold_full_q <= 1'b1;
            hold_data_q <= tx_data;
            hold_last_q <= tx_last;
        end else if (hold_to_shift) begin
            hold_full_q <= 1'b0;
        end
    end

    // Shift word, bit index and symbol timer
    always_ff @(posedge clk) begin
        if (clr) begin
            sh_data_q <= '0;
            sh_idx_q  <= '0;
            sh_last_q <= 1'b0;
            sym_cnt_q <= '0;
        end else begin
            if (hold_to_shift) begin
                sh_data_q <= hold_data_q;
                sh_idx_q  <= '0;
                sh_last_q <= hold_last_q;
            end else if (shift_bit) begin
                sh_idx_q  <= next_idx;
            end
            if (state_d != SHIFT || hold_to_shift || sym_edge)
                sym_cnt_q <= '0;
            else
                sym_cnt_q <= sym_cnt_q + CNT_W'(1);
        end
    end

    // Registered line outputs and sticky error flags
    always_ff @(posedge clk) begin
        if (clr) begin
            data_mod   <= 1'b0;
            sym_strobe <= 1'b0;
            err        <= 2'b00;
        end else begin
            sym_strobe <= emit;
            if (emit)
                data_mod <= emit_bit ^ wbit;
            else if (state_d != SHIFT)
                data_mod <= 1'b0;
            if (pkt_start) begin
                err <= 2'b00;
            end else begin
                if (underrun)   err[ERR_UNDERRUN]  <= 1'b1;
                if (lock_abort) err[ERR_LOCK_LOST] <= 1'b1;
            end
        end
    end

`ifdef ADPLL_TX_WHITEN_EN
    adpll_tx_whitener u_whiten (
        .clk     (clk),
        .rst     (clr),
        .load    (pkt_start),
        .seed_lo (channel),
        .advance (emit),
        .wbit    (wbit)
    );
`else
    // Without whitening the channel index has no consumer
    logic unused_channel;
    assign unused_channel = ^channel;
    assign wbit           = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_tx_serializer.sv
// Directed bench for adpll_tx_serializer: single word, lock wait, burst,
// underrun, lock loss, enable/reset mid-packet, and (with
// ADPLL_TX_WHITEN_EN) the whitened sequence for channel 37.
module tb_adpll_tx_serializer;

    localparam int SYM = 32;

    logic       clk = 1'b0;
    logic       rst, en, channel_lock, tx_valid, tx_last;
    logic [5:0] channel;
    logic [7:0] tx_data;
    logic       tx_ready, data_mod, sym_strobe, busy;
    logic [1:0] err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adpll_tx_serializer #(.SYM_CLKS(SYM), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .channel_lock (channel_lock),
        .channel      (channel),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .data_mod     (data_mod),
        .sym_strobe   (sym_strobe),
        .busy         (busy),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until a strobe is seen (bounded)
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sym_strobe && n < 400);
        if (!sym_strobe) chk("strobe_timeout", sym_strobe, 1);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic send_word(input logic [7:0] d, input logic last);
        int t;
        t        = 0;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        #1;
        while (!tx_ready && t < 600) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!tx_ready) chk("ready_timeout", tx_ready, 1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Checks bits start..7 of b; gaps must be exactly one symbol
    task automatic collect(input logic [7:0] b, input int start, input bit gap0, input string tag);
        int n;
        for (int i = start; i < 8; i++) begin
            wait_strobe(n);
            if (i != start || gap0) chk({tag, "_gap"}, n, SYM);
            chk({tag, "_bit"}, data_mod, b[i]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, bad;
        rst = 1'b1; en = 1'b1; channel_lock = 1'b1; channel = 6'd37;
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_data_mod", data_mod, 0);
        chk("rst_strobe", sym_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_tx_ready_in_rst", tx_ready, 0);
        rst = 1'b0;
        #1 chk("rst_tx_ready_released", tx_ready, 1);
        @(negedge clk);

`ifndef ADPLL_TX_WHITEN_EN
        // 1: single word 0xA5, lock already high
        send_word(8'hA5, 1'b1);
        collect(8'hA5, 0, 1'b0, "t1");
        repeat (31) @(negedge clk);
        chk("t1_last_bit_held", data_mod, 1);
        chk("t1_busy_last_bit", busy, 1);
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_data", data_mod, 0);
        chk("t1_no_9th_strobe", sym_strobe, 0);

        // 2: word 0x0F waits 100 clks for lock
        channel_lock = 1'b0;
        send_word(8'h0F, 1'b1);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (data_mod || sym_strobe) bad++;
        end
        chk("t2_quiet_while_waiting", bad, 0);
        chk("t2_busy_waiting", busy, 1);
        channel_lock = 1'b1;
        wait_strobe(n);
        chk("t2_first_bit_latency", n, 1);
        chk("t2_bit0", data_mod, 1);
        collect(8'h0F, 1, 1'b1, "t2");
        wait_idle("t2_idle");
        @(negedge clk);

        // 3: 3-word burst, host always valid
        fork
            begin
                send_word(8'h00, 1'b0);
                send_word(8'hFF, 1'b0);
                send_word(8'h55, 1'b1);
            end
            begin
                collect(8'h00, 0, 1'b0, "t3w0");
                collect(8'hFF, 0, 1'b1, "t3w1");
                collect(8'h55, 0, 1'b1, "t3w2");
            end
        join
        chk("t3_err", err, 0);
        wait_idle("t3_idle");
        @(negedge clk);

        // 4: non-last word with no follow-up -> underrun
        send_word(8'hBC, 1'b0);
        collect(8'hBC, 0, 1'b0, "t4");
        repeat (31) @(negedge clk);
        chk("t4_ready_low_on_abort", tx_ready, 0);
        @(negedge clk);
        chk("t4_err_underrun", err, 2'b01);
        chk("t4_data_zero", data_mod, 0);
        chk("t4_idle", busy, 0);
        chk("t4_no_strobe", sym_strobe, 0);
        send_word(8'h01, 1'b1);
        chk("t4_err_cleared", err, 0);
        collect(8'h01, 0, 1'b0, "t4b");
        wait_idle("t4b_idle");
        @(negedge clk);

        // 5: lock dropped during symbol 3 with a word waiting in hold
        fork
            begin
                send_word(8'hFF, 1'b0);
                send_word(8'h00, 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) wait_strobe(n);
            end
        join
        chk("t5_data_before_drop", data_mod, 1);
        channel_lock = 1'b0;
        #1 chk("t5_ready_low_on_abort", tx_ready, 0);
        @(negedge clk);
        chk("t5_err_lock", err, 2'b10);
        chk("t5_data_zero", data_mod, 0);
        chk("t5_idle", busy, 0);
        chk("t5_hold_discarded", tx_ready, 1);
        channel_lock = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", err, 2'b10);

        // en low clears sticky err and drops tx_ready
        en = 1'b0;
        #1 chk("en_ready_low", tx_ready, 0);
        @(negedge clk);
        chk("en_err_cleared", err, 0);
        chk("en_busy", busy, 0);
        en = 1'b1;
        @(negedge clk);
`else
        // 6: whitened word 0x00 on channel 37 (seed 7'h65)
        send_word(8'h00, 1'b1);
        collect(8'h8B, 0, 1'b0, "t6w");
        wait_idle("t6w_idle");
        @(negedge clk);
`endif

        // rst mid-packet returns everything to reset values next edge
        send_word(8'hFF, 1'b1);
        wait_strobe(n);
        wait_strobe(n);
        chk("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        #1 chk("rstmid_ready_in_rst", tx_ready, 0);
        @(negedge clk);
        chk("rstmid_data", data_mod, 0);
        chk("rstmid_strobe", sym_strobe, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_err", err, 0);
        rst = 1'b0;
        #1 chk("rstmid_ready_after", tx_ready, 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
